// File: rtl/writeback_regfile_if.sv
// Write-back stage bus: ALU result handshake, stall, read ports and status outputs.
interface writeback_regfile_if #(
    parameter int unsigned DATA_W = 32
);
    logic              WB_VALID;
    logic              WB_READY;
    logic [DATA_W-1:0] ALUOut;
    logic [4:0]        WriteReg;
    logic [5:0]        FuncCode;
    logic              Zero;
    logic              STALL;
    logic [4:0]        ReadReg1;
    logic [4:0]        ReadReg2;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic              WB_DONE;
    logic              Z_FLAG;
    logic              ILLEGAL;
    logic [15:0]       WB_COUNT;

    modport master (
        output WB_VALID, ALUOut, WriteReg, FuncCode, Zero, STALL, ReadReg1, ReadReg2,
        input  WB_READY, A, B, WB_DONE, Z_FLAG, ILLEGAL, WB_COUNT
    );

    modport slave (
        input  WB_VALID, ALUOut, WriteReg, FuncCode, Zero, STALL, ReadReg1, ReadReg2,
        output WB_READY, A, B, WB_DONE, Z_FLAG, ILLEGAL, WB_COUNT
    );
endinterface

// File: rtl/writeback_regfile.sv
// Write-back stage: one-entry pending register committing into a register file,
// with two combinational read ports that bypass from the pending entry.
module writeback_regfile #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned NREGS          = 32,
    parameter int unsigned ZERO_HARDWIRED = 0
) (
    input  logic                 CLK,
    input  logic                 RESET,
    writeback_regfile_if.slave   bus
);

    logic [DATA_W-1:0] regs_q [NREGS];

    logic              pend_v_q;
    logic [DATA_W-1:0] pend_data_q;
    logic [4:0]        pend_rd_q;
    logic              pend_legal_q;
    logic              pend_zero_q;

    logic              done_q;
    logic              z_flag_q;
    logic              illegal_q;
    logic [15:0]       count_q;

    logic wb_ready;
    logic accept;
    logic commit;
    logic reg_we;
    logic in_legal;
    logic zero_hw;

    assign zero_hw  = (ZERO_HARDWIRED != 0);
    assign wb_ready = !pend_v_q || !bus.STALL;
    assign accept   = bus.WB_VALID && wb_ready;
    assign commit   = pend_v_q && !bus.STALL;
    assign reg_we   = commit && pend_legal_q && !(zero_hw && pend_rd_q == 5'd0);

    always_comb begin
        in_legal = 1'b0;
        case (bus.FuncCode)
            6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42: in_legal = 1'b1;
            default:                                  in_legal = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pend_v_q     <= 1'b0;
            pend_data_q  <= '0;
            pend_rd_q    <= '0;
            pend_legal_q <= 1'b0;
            pend_zero_q  <= 1'b0;
        end else if (accept) begin
            pend_v_q     <= 1'b1;
            pend_data_q  <= bus.ALUOut;
            pend_rd_q    <= bus.WriteReg;
            pend_legal_q <= in_legal;
            pend_zero_q  <= bus.Zero;
        end else if (commit) begin
            pend_v_q <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            done_q    <= 1'b0;
            z_flag_q  <= 1'b0;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            done_q <= commit && pend_legal_q;
            if (commit) begin
                z_flag_q <= pend_zero_q;
                // Suppressed writes to a hardwired r0 still count as commits.
                if (pend_legal_q) begin
                    count_q <= count_q + 16'd1;
                end else begin
                    illegal_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (reg_we) begin
            regs_q[pend_rd_q] <= pend_data_q;
        end
    end

    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    // Bypass only legal pending results; illegal ones never reach the file.
    always_comb begin
        rd_a = regs_q[bus.ReadReg1];
        if (pend_v_q && pend_legal_q && pend_rd_q == bus.ReadReg1) begin
            rd_a = pend_data_q;
        end
        if (zero_hw && bus.ReadReg1 == 5'd0) begin
            rd_a = '0;
        end
    end

    always_comb begin
        rd_b = regs_q[bus.ReadReg2];
        if (pend_v_q && pend_legal_q && pend_rd_q == bus.ReadReg2) begin
            rd_b = pend_data_q;
        end
        if (zero_hw && bus.ReadReg2 == 5'd0) begin
            rd_b = '0;
        end
    end

    assign bus.WB_READY = wb_ready;
    assign bus.A        = rd_a;
    assign bus.B        = rd_b;
    assign bus.WB_DONE  = done_q;
    assign bus.Z_FLAG   = z_flag_q;
    assign bus.ILLEGAL  = illegal_q;
    assign bus.WB_COUNT = count_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: two instances differing only in ZERO_HARDWIRED.
module tb_writeback_regfile;

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    always #5 CLK = ~CLK;

    writeback_regfile_if #(.DATA_W(32)) bus ();
    writeback_regfile_if #(.DATA_W(32)) bus_z ();

    assign bus_z.WB_VALID = bus.WB_VALID;
    assign bus_z.ALUOut   = bus.ALUOut;
    assign bus_z.WriteReg = bus.WriteReg;
    assign bus_z.FuncCode = bus.FuncCode;
    assign bus_z.Zero     = bus.Zero;
    assign bus_z.STALL    = bus.STALL;
    assign bus_z.ReadReg1 = bus.ReadReg1;
    assign bus_z.ReadReg2 = bus.ReadReg2;

    writeback_regfile #(.DATA_W(32), .NREGS(32), .ZERO_HARDWIRED(0)) u_dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    writeback_regfile #(.DATA_W(32), .NREGS(32), .ZERO_HARDWIRED(1)) u_dut_z (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus_z)
    );

    int tests = 0;
    int fails = 0;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        bus.WB_VALID = 1'b0; bus.ALUOut = '0; bus.WriteReg = '0; bus.FuncCode = '0;
        bus.Zero = 1'b0; bus.STALL = 1'b0; bus.ReadReg1 = 5'd5; bus.ReadReg2 = 5'd9;
        #2;
        tests++; if (bus.WB_READY !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b want 1", bus.WB_READY); end
        tests++; if (bus.WB_DONE !== 1'b0) begin fails++; $display("FAIL rst_done: got %b want 0", bus.WB_DONE); end
        tests++; if (bus.Z_FLAG !== 1'b0) begin fails++; $display("FAIL rst_zflag: got %b want 0", bus.Z_FLAG); end
        tests++; if (bus.ILLEGAL !== 1'b0) begin fails++; $display("FAIL rst_illegal: got %b want 0", bus.ILLEGAL); end
        tests++; if (bus.WB_COUNT !== 16'h0) begin fails++; $display("FAIL rst_count: got %h want 0", bus.WB_COUNT); end
        tests++; if (bus.A !== 32'h0 || bus.B !== 32'h0) begin fails++; $display("FAIL rst_ab: got %h/%h want 0/0", bus.A, bus.B); end
        @(negedge CLK);
        RESET = 1'b1;
        step();
    endtask

    task automatic test_basic();
        bus.WB_VALID = 1'b1; bus.ALUOut = 32'h7; bus.WriteReg = 5'd2; bus.FuncCode = 6'd32;
        bus.Zero = 1'b1; bus.ReadReg1 = 5'd2; bus.ReadReg2 = 5'd2;
        step();
        tests++; if (bus.A !== 32'h7 || bus.B !== 32'h7) begin fails++; $display("FAIL basic_bypass: got %h/%h want 7/7", bus.A, bus.B); end
        tests++; if (u_dut.regs_q[2] !== 32'h0) begin fails++; $display("FAIL basic_not_yet: got %h want 0", u_dut.regs_q[2]); end
        tests++; if (bus.WB_DONE !== 1'b0) begin fails++; $display("FAIL basic_done_early: got %b want 0", bus.WB_DONE); end
        bus.WB_VALID = 1'b0;
        step();
        tests++; if (u_dut.regs_q[2] !== 32'h7) begin fails++; $display("FAIL basic_commit: got %h want 7", u_dut.regs_q[2]); end
        tests++; if (bus.WB_DONE !== 1'b1) begin fails++; $display("FAIL basic_done: got %b want 1", bus.WB_DONE); end
        tests++; if (bus.WB_COUNT !== 16'd1) begin fails++; $display("FAIL basic_count: got %0d want 1", bus.WB_COUNT); end
        tests++; if (bus.Z_FLAG !== 1'b1) begin fails++; $display("FAIL basic_zflag: got %b want 1", bus.Z_FLAG); end
        tests++; if (bus.A !== 32'h7) begin fails++; $display("FAIL basic_read: got %h want 7", bus.A); end
        step();
        tests++; if (bus.WB_DONE !== 1'b0) begin fails++; $display("FAIL basic_done_pulse: got %b want 0", bus.WB_DONE); end
    endtask

    task automatic test_stall();
        bus.WB_VALID = 1'b1; bus.ALUOut = 32'hA; bus.WriteReg = 5'd5; bus.FuncCode = 6'd34;
        bus.Zero = 1'b0; bus.ReadReg1 = 5'd5;
        step();
        bus.STALL = 1'b1; bus.ALUOut = 32'h55; bus.WriteReg = 5'd6;
        #1;
        tests++; if (bus.WB_READY !== 1'b0) begin fails++; $display("FAIL stall_ready0: got %b want 0", bus.WB_READY); end
        for (int i = 0; i < 3; i++) begin
            step();
            tests++; if (bus.WB_READY !== 1'b0) begin fails++; $display("FAIL stall_ready[%0d]: got %b want 0", i, bus.WB_READY); end
            tests++; if (u_dut.regs_q[5] !== 32'h0) begin fails++; $display("FAIL stall_reg5[%0d]: got %h want 0", i, u_dut.regs_q[5]); end
            tests++; if (bus.A !== 32'hA) begin fails++; $display("FAIL stall_bypass[%0d]: got %h want a", i, bus.A); end
        end
        bus.STALL = 1'b0; bus.WB_VALID = 1'b0;
        #1;
        tests++; if (bus.WB_READY !== 1'b1) begin fails++; $display("FAIL stall_release_ready: got %b want 1", bus.WB_READY); end
        step();
        tests++; if (u_dut.regs_q[5] !== 32'hA) begin fails++; $display("FAIL stall_commit: got %h want a", u_dut.regs_q[5]); end
        tests++; if (u_dut.regs_q[6] !== 32'h0) begin fails++; $display("FAIL stall_ignored: got %h want 0", u_dut.regs_q[6]); end
        tests++; if (bus.WB_COUNT !== 16'd2) begin fails++; $display("FAIL stall_count: got %0d want 2", bus.WB_COUNT); end
        tests++; if (bus.Z_FLAG !== 1'b0) begin fails++; $display("FAIL stall_zflag: got %b want 0", bus.Z_FLAG); end
        tests++; if (bus.WB_DONE !== 1'b1) begin fails++; $display("FAIL stall_done: got %b want 1", bus.WB_DONE); end
    endtask

    task automatic test_back_to_back();
        bus.WB_VALID = 1'b1; bus.ALUOut = 32'h1; bus.WriteReg = 5'd3; bus.FuncCode = 6'd36;
        bus.ReadReg1 = 5'd3;
        step();
        tests++; if (bus.A !== 32'h1) begin fails++; $display("FAIL b2b_first: got %h want 1", bus.A); end
        bus.ALUOut = 32'h2; bus.FuncCode = 6'd37;
        step();
        tests++; if (bus.A !== 32'h2) begin fails++; $display("FAIL b2b_bypass: got %h want 2", bus.A); end
        tests++; if (u_dut.regs_q[3] !== 32'h1) begin fails++; $display("FAIL b2b_mid: got %h want 1", u_dut.regs_q[3]); end
        bus.WB_VALID = 1'b0;
        step();
        tests++; if (u_dut.regs_q[3] !== 32'h2) begin fails++; $display("FAIL b2b_final: got %h want 2", u_dut.regs_q[3]); end
        tests++; if (bus.WB_COUNT !== 16'd4) begin fails++; $display("FAIL b2b_count: got %0d want 4", bus.WB_COUNT); end
    endtask

    task automatic test_illegal();
        bus.WB_VALID = 1'b1; bus.ALUOut = 32'hFF; bus.WriteReg = 5'd4; bus.FuncCode = 6'd13;
        bus.ReadReg1 = 5'd4;
        step();
        tests++; if (bus.A !== 32'h0) begin fails++; $display("FAIL ill_no_bypass: got %h want 0", bus.A); end
        tests++; if (bus.ILLEGAL !== 1'b0) begin fails++; $display("FAIL ill_early: got %b want 0", bus.ILLEGAL); end
        bus.WB_VALID = 1'b0;
        step();
        tests++; if (bus.ILLEGAL !== 1'b1) begin fails++; $display("FAIL ill_flag: got %b want 1", bus.ILLEGAL); end
        tests++; if (bus.WB_DONE !== 1'b0) begin fails++; $display("FAIL ill_done: got %b want 0", bus.WB_DONE); end
        tests++; if (bus.WB_COUNT !== 16'd4) begin fails++; $display("FAIL ill_count: got %0d want 4", bus.WB_COUNT); end
        tests++; if (u_dut.regs_q[4] !== 32'h0) begin fails++; $display("FAIL ill_reg4: got %h want 0", u_dut.regs_q[4]); end
        step();
        tests++; if (bus.ILLEGAL !== 1'b1) begin fails++; $display("FAIL ill_sticky: got %b want 1", bus.ILLEGAL); end
    endtask

    task automatic test_funcs();
        logic [5:0] codes [6];
        codes = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42};
        for (int i = 0; i < 6; i++) begin
            bus.WB_VALID = 1'b1; bus.ALUOut = 32'h100 + 32'(i);
            bus.WriteReg = 5'(10 + i); bus.FuncCode = codes[i];
            step();
        end
        bus.WB_VALID = 1'b0;
        step();
        for (int i = 0; i < 6; i++) begin
            bus.ReadReg2 = 5'(10 + i);
            #1;
            tests++; if (bus.B !== 32'h100 + 32'(i)) begin fails++; $display("FAIL func_%0d: got %h want %h", codes[i], bus.B, 32'h100 + 32'(i)); end
        end
        tests++; if (bus.WB_COUNT !== 16'd10) begin fails++; $display("FAIL func_count: got %0d want 10", bus.WB_COUNT); end
    endtask

    task automatic test_zero_reg();
        bus.WB_VALID = 1'b1; bus.ALUOut = 32'h5; bus.WriteReg = 5'd0; bus.FuncCode = 6'd42;
        bus.Zero = 1'b1; bus.ReadReg1 = 5'd0;
        step();
        tests++; if (bus.A !== 32'h5) begin fails++; $display("FAIL r0_bypass_soft: got %h want 5", bus.A); end
        tests++; if (bus_z.A !== 32'h0) begin fails++; $display("FAIL r0_bypass_hard: got %h want 0", bus_z.A); end
        bus.WB_VALID = 1'b0;
        step();
        tests++; if (bus.A !== 32'h5) begin fails++; $display("FAIL r0_soft: got %h want 5", bus.A); end
        tests++; if (bus_z.A !== 32'h0) begin fails++; $display("FAIL r0_hard: got %h want 0", bus_z.A); end
        tests++; if (bus_z.WB_COUNT !== 16'd11) begin fails++; $display("FAIL r0_hard_count: got %0d want 11", bus_z.WB_COUNT); end
        tests++; if (bus.WB_COUNT !== 16'd11) begin fails++; $display("FAIL r0_soft_count: got %0d want 11", bus.WB_COUNT); end
    endtask

    task automatic test_reset_pending();
        bus.WB_VALID = 1'b1; bus.ALUOut = 32'h99; bus.WriteReg = 5'd7; bus.FuncCode = 6'd32;
        bus.Zero = 1'b0; bus.ReadReg1 = 5'd7; bus.ReadReg2 = 5'd3;
        step();
        bus.WB_VALID = 1'b0; bus.STALL = 1'b1;
        step();
        tests++; if (bus.A !== 32'h99) begin fails++; $display("FAIL rp_held: got %h want 99", bus.A); end
        RESET = 1'b0;
        #1;
        tests++; if (bus.WB_READY !== 1'b1) begin fails++; $display("FAIL rp_ready: got %b want 1", bus.WB_READY); end
        tests++; if (bus.WB_COUNT !== 16'd0) begin fails++; $display("FAIL rp_count: got %0d want 0", bus.WB_COUNT); end
        tests++; if (bus.ILLEGAL !== 1'b0 || bus.Z_FLAG !== 1'b0 || bus.WB_DONE !== 1'b0) begin
            fails++; $display("FAIL rp_flags: got ill=%b z=%b done=%b want 0/0/0", bus.ILLEGAL, bus.Z_FLAG, bus.WB_DONE);
        end
        tests++; if (bus.A !== 32'h0 || bus.B !== 32'h0) begin fails++; $display("FAIL rp_ab: got %h/%h want 0/0", bus.A, bus.B); end
        bus.STALL = 1'b0;
        step();
        RESET = 1'b1;
        step();
        tests++; if (u_dut.regs_q[7] !== 32'h0 || bus.A !== 32'h0) begin
            fails++; $display("FAIL rp_dropped: got reg=%h A=%h want 0/0", u_dut.regs_q[7], bus.A);
        end
        tests++; if (bus.WB_COUNT !== 16'd0) begin fails++; $display("FAIL rp_count_after: got %0d want 0", bus.WB_COUNT); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_illegal();
        test_funcs();
        test_zero_reg();
        test_reset_pending();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/writeback_regfile.md
# writeback_regfile

Write-back stage and register file for the MIPS R-type datapath, sitting directly downstream of the ALU. It accepts each ALU result with its destination register and function code through a valid/ready handshake. It holds the result in a one-entry pending register and commits it to a 32x32 register file one cycle later, unless stalled. Its two combinational read ports, with bypass from the pending entry, feed operands A/B back to the ALU.

## Interface
Parameters:
- DATA_W, 32, register and data width
- NREGS, 32, number of registers (address width fixed at 5)
- ZERO_HARDWIRED, 0, 1 = register 0 reads 0 and ignores writes; 0 = register 0 is ordinary

Ports:
- CLK  in  1  clock; all state updates on posedge
- RESET  in  1  asynchronous, active-low reset
- WB_VALID  in  1  ALU result presented this cycle
- WB_READY  out  1  stage can accept this cycle
- ALUOut  in  DATA_W  result to write
- WriteReg  in  5  destination register
- FuncCode  in  6  function code of the producing instruction
- Zero  in  1  ALU zero flag for this result
- STALL  in  1  blocks commit of the pending entry
- ReadReg1, ReadReg2  in  5  read addresses
- A, B  out  DATA_W  read data, combinational
- WB_DONE  out  1  one-cycle pulse after each commit
- Z_FLAG  out  1  Zero of the last committed result
- ILLEGAL  out  1  sticky flag for an unsupported FuncCode
- WB_COUNT  out  16  number of committed writes, wraps at 16'hFFFF -> 0

## Operation
- Legal FuncCodes: 32 (ADD), 34 (SUB), 36 (AND), 37 (OR), 39 (NOR), 42 (SLT).
- Accept condition: WB_VALID & WB_READY at a posedge. On accept, load the pending entry {pend_v=1, data, rd, legal, zero}.
- Commit condition: pend_v & !STALL at a posedge. On commit:
  - If legal, write REGS[rd] = data. The write is suppressed when rd==0 and ZERO_HARDWIRED=1.
  - Z_FLAG <= zero. WB_COUNT increments on every commit, including suppressed rd 0 writes.
  - If not legal, there is no register write and no count increment. ILLEGAL <= 1.
  - pend_v clears unless a new accept occurs on the same edge.
- WB_READY = !pend_v | !STALL. A new entry may be accepted on the same edge the old one commits.
- Read ports:
  - A = bypass if pend_v & legal & pend_rd==ReadReg1, otherwise REGS[ReadReg1]. B is the same using ReadReg2.
  - With ZERO_HARDWIRED=1, address 0 always reads 0, including through bypass.
- ILLEGAL clears only on reset.
- WB_DONE is registered: it is 1 during the cycle following a legal commit edge, else 0.

## Timing
- Reset (RESET=0, asynchronous):
  - All REGS = 0, pend_v = 0.
  - WB_READY = 1, WB_DONE = 0, Z_FLAG = 0, ILLEGAL = 0, WB_COUNT = 0.
  - A and B read 0.
- Reset asserted mid-operation drops the pending entry without writing it.
- Latency: accept at edge N; REGS updated at edge N+1 if STALL=0 at N+1. Bypass makes the data visible on A/B from just after edge N.
- While STALL=1 with pend_v=1: WB_READY=0, the pending entry is held unchanged, and WB_VALID is ignored.
- Back-to-back same-destination writes (accept X at N, Y at N+1): REGS holds X after N+1 and Y after N+2. A shows Y from N+1.
- Read of a register being committed at the same edge returns the new value after the edge.
- WB_COUNT wrap: 16'hFFFF plus one commit gives 16'h0000.

## Test plan
- Reset, then accept ALUOut=32'h7, WriteReg=2, FuncCode=32 with STALL=0 -> A (ReadReg1=2) = 7 one edge after accept; REGS[2]=7 and WB_DONE=1 after next edge; WB_COUNT=1.
- Accept 32'hA to r5, then STALL=1 for 3 cycles -> WB_READY=0 for those cycles, REGS[5] still 0, A (ReadReg1=5) = 32'hA via bypass; release STALL -> commit, WB_READY=1.
- Back-to-back writes 32'h1 then 32'h2 to r3 on consecutive cycles -> A (ReadReg1=3) = 2 after the second accept; final REGS[3]=2; WB_COUNT=2.
- FuncCode=13 with WriteReg=4, ALUOut=32'hFF -> ILLEGAL=1, REGS[4] unchanged (0), WB_COUNT unchanged, WB_DONE stays 0.
- ZERO_HARDWIRED=1: write 32'h5 to r0 -> A (ReadReg1=0) = 0 at all times, WB_COUNT increments. ZERO_HARDWIRED=0: A (ReadReg1=0) = 5.
- Assert RESET low while pend_v=1 -> entry dropped, all outputs at reset values, target register remains 0 after RESET goes high.
